doitgen_seq_ctrl: RTL and testbench

- Sequential controller and engine for the doitgen kernel: Aout[r][q][p] = sum over s of A[r][q][s]*X[s][p], then A[r][q][*] is replaced by Aout[r][q][*].
- Replaces the single-cycle, fully unrolled loop nest with one shared multiply-accumulate unit, sequenced by an FSM over the r/q/p/s loop counters.
- Uses a start/busy/done handshake so that upstream loaders and downstream consumers can be cycle-accurate.

---
 rtl/doitgen_pkg.sv | 20 ++
 rtl/doitgen_mac.sv | 16 +
 rtl/doitgen_seq_ctrl.sv | 175 +++++++++++++++++
 tb/tb_doitgen_seq_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/doitgen_pkg.sv
// Shared types and index helpers for the sequential doitgen engine.
package doitgen_pkg;

  localparam int unsigned DefDw  = 8;
  localparam int unsigned DefDim = 2;

  typedef enum logic [2:0] {StIdle, StLoad, StMac, StWb, StDone} state_e;

  // Flat index of A[r][q][p]; element 0 is packed at the MSBs.
  function automatic int unsigned idx3(input int unsigned r, input int unsigned q,
                                       input int unsigned p, input int unsigned dim);
    return (r * dim + q) * dim + p;
  endfunction

  function automatic int unsigned idx2(input int unsigned s, input int unsigned p,
                                       input int unsigned dim);
    return s * dim + p;
  endfunction

endpackage

// File: rtl/doitgen_mac.sv
// Combinational DW-bit multiply-add; product and sum wrap modulo 2^DW.
module doitgen_mac #(
  parameter int unsigned DW = 8
) (
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  input  logic [DW-1:0] i_acc,
  output logic [DW-1:0] o_acc
);

  logic [DW-1:0] w_prod;

  assign w_prod = i_a * i_b;
  assign o_acc  = i_acc + w_prod;

endmodule

// File: rtl/doitgen_seq_ctrl.sv
// Sequential doitgen engine: one shared MAC stepped by an FSM over r/q/p/s,
// with start/busy/done handshake and in-place row write-back.
module doitgen_seq_ctrl
  import doitgen_pkg::*;
#(
  parameter int unsigned DW  = DefDw,
  parameter int unsigned DIM = DefDim,
  parameter int unsigned CW  = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [CW-1:0]             nr,
  input  logic [CW-1:0]             nq,
  input  logic [CW-1:0]             np,
  input  logic [DW*DIM*DIM*DIM-1:0] a_in,
  input  logic [DW*DIM*DIM-1:0]     x_in,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [DW*DIM*DIM*DIM-1:0] a_out
);

  localparam int unsigned NA  = DIM * DIM * DIM;
  localparam int unsigned NX  = DIM * DIM;
  localparam int unsigned AW  = DW * NA;
  localparam int unsigned XW  = DW * NX;
  localparam int unsigned AIW = $clog2(NA);
  localparam int unsigned XIW = $clog2(NX);
  localparam int unsigned PW  = $clog2(DIM);

  state_e        r_state, w_state_d;
  logic [CW-1:0] r_nr, r_nq, r_np;
  logic [CW-1:0] r_r, r_q, r_p, r_s;
  logic [DW-1:0] r_acc;
  logic [DW-1:0] r_a_w    [NA];
  logic [DW-1:0] r_x_w    [NX];
  logic [DW-1:0] r_rowbuf [DIM];
  logic          r_done, r_err;
  logic [AW-1:0] r_a_out;

  logic [CW-1:0]  w_nr_m1, w_nq_m1, w_np_m1;
  logic           w_dims_ok, w_s_last, w_p_last, w_q_last, w_r_last;
  logic [AIW-1:0] w_a_idx;
  logic [XIW-1:0] w_x_idx;
  logic [DW-1:0]  w_acc_next;
  logic [AW-1:0]  w_a_pack;

  assign w_nr_m1 = r_nr - CW'(1);
  assign w_nq_m1 = r_nq - CW'(1);
  assign w_np_m1 = r_np - CW'(1);

  assign w_dims_ok = (r_nr != '0) && (r_nq != '0) && (r_np != '0) &&
                     (r_nr <= CW'(DIM)) && (r_nq <= CW'(DIM)) && (r_np <= CW'(DIM));

  assign w_s_last = (r_s == w_np_m1);
  assign w_p_last = (r_p == w_np_m1);
  assign w_q_last = (r_q == w_nq_m1);
  assign w_r_last = (r_r == w_nr_m1);

  assign w_a_idx = AIW'(idx3(32'(r_r), 32'(r_q), 32'(r_s), DIM));
  assign w_x_idx = XIW'(idx2(32'(r_s), 32'(r_p), DIM));

  doitgen_mac #(
    .DW(DW)
  ) u_mac (
    .i_a  (r_a_w[w_a_idx]),
    .i_b  (r_x_w[w_x_idx]),
    .i_acc(r_acc),
    .o_acc(w_acc_next)
  );

  always_comb begin
    w_a_pack = '0;
    for (int i = 0; i < int'(NA); i++) begin
      w_a_pack[AW-1-DW*i -: DW] = r_a_w[i];
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: if (start) w_state_d = StLoad;
      StLoad: w_state_d = w_dims_ok ? StMac : StDone;
      StMac:  if (w_s_last && w_p_last) w_state_d = StWb;
      StWb:   if (w_r_last && w_q_last) w_state_d = StDone;
              else w_state_d = StMac;
      StDone: w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nr    <= '0;
      r_nq    <= '0;
      r_np    <= '0;
      r_r     <= '0;
      r_q     <= '0;
      r_p     <= '0;
      r_s     <= '0;
      r_acc   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_a_out <= '0;
      for (int i = 0; i < int'(NA); i++) r_a_w[i] <= '0;
      for (int i = 0; i < int'(NX); i++) r_x_w[i] <= '0;
      for (int i = 0; i < int'(DIM); i++) r_rowbuf[i] <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        StIdle: begin
          if (start) begin
            r_nr <= nr;
            r_nq <= nq;
            r_np <= np;
            for (int i = 0; i < int'(NA); i++) r_a_w[i] <= a_in[AW-1-DW*i -: DW];
            for (int i = 0; i < int'(NX); i++) r_x_w[i] <= x_in[XW-1-DW*i -: DW];
          end
        end
        StLoad: begin
          r_r   <= '0;
          r_q   <= '0;
          r_p   <= '0;
          r_s   <= '0;
          r_acc <= '0;
        end
        StMac: begin
          // A_w stays untouched here so every p of a row sees the original row.
          if (w_s_last) begin
            r_rowbuf[PW'(r_p)] <= w_acc_next;
            r_acc <= '0;
            r_s   <= '0;
            if (!w_p_last) r_p <= r_p + CW'(1);
          end else begin
            r_acc <= w_acc_next;
            r_s   <= r_s + CW'(1);
          end
        end
        StWb: begin
          for (int unsigned k = 0; k < DIM; k++) begin
            if (k < 32'(r_np)) begin
              r_a_w[AIW'(idx3(32'(r_r), 32'(r_q), k, DIM))] <= r_rowbuf[k];
            end
          end
          r_p <= '0;
          if (w_q_last) begin
            r_q <= '0;
            r_r <= r_r + CW'(1);
          end else begin
            r_q <= r_q + CW'(1);
          end
        end
        StDone: begin
          r_done <= 1'b1;
          r_err  <= !w_dims_ok;
          if (w_dims_ok) r_a_out <= w_a_pack;
        end
        default: ;
      endcase
    end
  end

  assign busy  = (r_state == StLoad) || (r_state == StMac) || (r_state == StWb);
  assign done  = r_done;
  assign err   = r_err;
  assign a_out = r_a_out;

endmodule

// File: tb/tb_doitgen_seq_ctrl.sv
// Scoreboard bench for doitgen_seq_ctrl: stimulus pushes expected results,
// a monitor pops and compares whenever done pulses.
module tb_doitgen_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  nr, nq, np;
  logic [63:0] a_in;
  logic [31:0] x_in;
  logic        busy, done, err;
  logic [63:0] a_out;

  typedef struct {
    int          id;
    logic [63:0] a;
    logic        e;
    int          lat;
    int          t0;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_miss = 0;
  logic [63:0] last_a = '0;

  doitgen_seq_ctrl #(
    .DW (8),
    .DIM(2),
    .CW (2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .nr   (nr),
    .nq   (nq),
    .np   (np),
    .a_in (a_in),
    .x_in (x_in),
    .busy (busy),
    .done (done),
    .err  (err),
    .a_out(a_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_done: got done=1 want no done at cycle %0d", cyc);
      end else begin
        cur = sb.pop_front();
        chk($sformatf("v%0d_a_out", cur.id), a_out, cur.a);
        chk($sformatf("v%0d_err", cur.id), {63'b0, err}, {63'b0, cur.e});
        chk($sformatf("v%0d_latency", cur.id), 64'(cyc - cur.t0), 64'(cur.lat));
      end
    end else if (rst_n && err) begin
      n_vec++;
      n_miss++;
      $display("FAIL err_without_done: got err=1 done=0 want err only with done");
    end
  end

  task automatic run(input int id, input logic [1:0] r, input logic [1:0] q,
                     input logic [1:0] p, input logic [63:0] a, input logic [31:0] x,
                     input logic [63:0] ea, input logic ee, input int lat, input int bsy,
                     input int restart);
    exp_t e;
    int   busy_cnt;
    bit   fin;
    @(negedge clk);
    nr    = r;
    nq    = q;
    np    = p;
    a_in  = a;
    x_in  = x;
    start = 1'b1;
    e.id  = id;
    e.a   = ea;
    e.e   = ee;
    e.lat = lat;
    e.t0  = cyc + 1;
    sb.push_back(e);
    busy_cnt = 0;
    fin      = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      start = (restart != 0) && (i == restart);
      if (start) a_in = ~a;
      busy_cnt += int'(busy);
      #1;
      if (sb.size() == 0) begin
        fin = 1'b1;
        break;
      end
    end
    if (!fin) begin
      n_vec++;
      n_miss++;
      $display("FAIL v%0d_timeout: got no done want done within 100 cycles", id);
      sb.delete();
    end
    chk($sformatf("v%0d_busy_cycles", id), 64'(busy_cnt), 64'(bsy));
    if (!ee) last_a = ea;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    nr    = '0;
    nq    = '0;
    np    = '0;
    a_in  = '0;
    x_in  = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", {63'b0, busy}, 64'd0);
    chk("reset_done", {63'b0, done}, 64'd0);
    chk("reset_err", {63'b0, err}, 64'd0);
    chk("reset_a_out", a_out, 64'd0);
    rst_n = 1'b1;

    // 1x1x1: 3*5 = 15, everything outside the box passes through
    run(1, 2'd1, 2'd1, 2'd1, 64'h03112233_44556677, 32'h05998877,
        64'h0F112233_44556677, 1'b0, 4, 3, 0);
    // identity X leaves A unchanged
    run(2, 2'd2, 2'd2, 2'd2, 64'h01020304_05060708, 32'h01000001,
        64'h01020304_05060708, 1'b0, 22, 21, 0);
    // X={1,2,3,4}: row {a0,a1} -> {a0+3a1, 2a0+4a1}
    run(3, 2'd2, 2'd2, 2'd2, 64'h01010201_03100101, 32'h01020304,
        64'h04060508_33460406, 1'b0, 22, 21, 0);
    run(4, 2'd2, 2'd2, 2'd2, 64'h01010101_01010101, 32'h01020304,
        64'h04060406_04060406, 1'b0, 22, 21, 0);
    // wrap cases
    run(5, 2'd1, 2'd1, 2'd1, 64'h10AABBCC_DDEEFF00, 32'h10000000,
        64'h00AABBCC_DDEEFF00, 1'b0, 4, 3, 0);
    run(6, 2'd1, 2'd1, 2'd1, 64'hFF000000_00000000, 32'h02000000,
        64'hFE000000_00000000, 1'b0, 4, 3, 0);
    // partial boxes
    run(7, 2'd2, 2'd1, 2'd1, 64'h02112233_05445566, 32'h03778899,
        64'h06112233_0F445566, 1'b0, 6, 5, 0);
    run(8, 2'd1, 2'd2, 2'd2, 64'h01010201_AABBCCDD, 32'h01020304,
        64'h04060508_AABBCCDD, 1'b0, 12, 11, 0);
    // illegal dimensions keep the previous a_out
    run(9, 2'd2, 2'd2, 2'd0, 64'h11111111_11111111, 32'h01020304,
        last_a, 1'b1, 2, 1, 0);
    run(10, 2'd3, 2'd2, 2'd2, 64'h22222222_22222222, 32'h01020304,
        last_a, 1'b1, 2, 1, 0);
    // second start while busy must be ignored
    run(11, 2'd2, 2'd2, 2'd2, 64'h01010201_01010201, 32'h01020304,
        64'h04060508_04060508, 1'b0, 22, 21, 5);

    // reset mid-run aborts with no done
    @(negedge clk);
    nr    = 2'd2;
    nq    = 2'd2;
    np    = 2'd2;
    a_in  = 64'h0102030405060708;
    x_in  = 32'h01020304;
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {63'b0, busy}, 64'd0);
    chk("abort_done", {63'b0, done}, 64'd0);
    chk("abort_err", {63'b0, err}, 64'd0);
    chk("abort_a_out", a_out, 64'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    last_a = '0;
    repeat (3) @(negedge clk);

    run(12, 2'd2, 2'd2, 2'd2, 64'h01020304_05060708, 32'h01000001,
        64'h01020304_05060708, 1'b0, 22, 21, 0);
    run(13, 2'd0, 2'd1, 2'd1, 64'h33333333_33333333, 32'h01020304,
        last_a, 1'b1, 2, 1, 0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
